scr1_tcm_banked: RTL and testbench

Parametrised multi-bank tightly-coupled memory shared by the core instruction and data ports. Word-interleaved single-port banks allow both ports to proceed in the same cycle when they hit different banks. Same-bank conflicts are arbitrated with bounded instruction-port starvation. Adds configurable read latency, out-of-range and misalignment error responses, and a conflict counter.

---
 rtl/scr1_tcm_banked_if.sv | 32 +++
 rtl/scr1_tcm_banked.sv | 230 +++++++++++++++++++++++
 tb/tb_scr1_tcm_banked.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/scr1_tcm_banked_if.sv
// Core-side bus bundle for the banked TCM: one instruction read port and one data port.
// Response encoding: 0 NOTRDY, 1 RDY_OK, 2 RDY_ER; cmd 0 RD / 1 WR; width 0 BYTE, 1 HWORD, 2 WORD.
interface scr1_tcm_banked_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_req_ack;
    logic [31:0] imem_rdata;
    logic [1:0]  imem_resp;

    logic        dmem_req;
    logic        dmem_cmd;
    logic [1:0]  dmem_width;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_req_ack;
    logic [31:0] dmem_rdata;
    logic [1:0]  dmem_resp;

    modport master (
        output imem_req, imem_addr,
        input  imem_req_ack, imem_rdata, imem_resp,
        output dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
        input  dmem_req_ack, dmem_rdata, dmem_resp
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_req_ack, imem_rdata, imem_resp,
        input  dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
        output dmem_req_ack, dmem_rdata, dmem_resp
    );
endinterface

// File: rtl/scr1_tcm_banked.sv
// Word-interleaved multi-bank TCM shared by imem and dmem ports, with same-bank
// arbitration (bounded imem starvation), error responses and a conflict counter.
module scr1_tcm_banked #(
    parameter int unsigned SCR1_TCM_SIZE = 32'h0001_0000,
    parameter int unsigned NUM_BANKS     = 2,
    parameter int unsigned RD_LATENCY    = 1,
    parameter int unsigned STARVE_LIMIT  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    scr1_tcm_banked_if.slave     bus,
    output logic [15:0]          conflict_cnt
);
    localparam int unsigned OFS_W    = $clog2(SCR1_TCM_SIZE);
    localparam int unsigned BANK_W   = $clog2(NUM_BANKS);
    localparam int unsigned BANK_IW  = (BANK_W == 0) ? 1 : BANK_W;
    localparam int unsigned ROW_W    = OFS_W - 2 - BANK_W;
    localparam int unsigned ROW_IW   = (ROW_W == 0) ? 1 : ROW_W;
    localparam int unsigned ROWS     = 1 << ROW_W;
    localparam int unsigned STARVE_W = 4;
    localparam int unsigned CNT_W    = 16;

    localparam logic [1:0] RESP_NOTRDY = 2'd0;
    localparam logic [1:0] RESP_OK     = 2'd1;
    localparam logic [1:0] RESP_ER     = 2'd2;
    localparam logic [1:0] WIDTH_BYTE  = 2'd0;
    localparam logic [1:0] WIDTH_HWORD = 2'd1;
    localparam logic [1:0] WIDTH_WORD  = 2'd2;
    localparam logic       CMD_WR      = 1'b1;

    // Request decode
    logic               i_inrange_c, d_inrange_c, d_aligned_c;
    logic               i_use_c, d_use_c, d_wr_c;
    logic [BANK_IW-1:0] i_bank_c, d_bank_c;
    logic [ROW_IW-1:0]  i_row_c, d_row_c;
    logic [3:0]         d_be_c;
    logic [31:0]        d_wdata_c;

    always_comb begin
        i_inrange_c = (bus.imem_addr >> OFS_W) == 32'd0;
        d_inrange_c = (bus.dmem_addr >> OFS_W) == 32'd0;
        i_bank_c    = BANK_IW'((bus.imem_addr >> 2) & 32'(NUM_BANKS - 1));
        d_bank_c    = BANK_IW'((bus.dmem_addr >> 2) & 32'(NUM_BANKS - 1));
        i_row_c     = ROW_IW'(bus.imem_addr >> (2 + BANK_W));
        d_row_c     = ROW_IW'(bus.dmem_addr >> (2 + BANK_W));
        d_wr_c      = (bus.dmem_cmd == CMD_WR);
        d_aligned_c = 1'b0;
        d_be_c      = 4'b0000;
        d_wdata_c   = bus.dmem_wdata;
        case (bus.dmem_width)
            WIDTH_BYTE: begin
                d_aligned_c = 1'b1;
                d_be_c      = 4'b0001 << bus.dmem_addr[1:0];
                d_wdata_c   = {4{bus.dmem_wdata[7:0]}};
            end
            WIDTH_HWORD: begin
                d_aligned_c = ~bus.dmem_addr[0];
                d_be_c      = 4'b0011 << {bus.dmem_addr[1], 1'b0};
                d_wdata_c   = {2{bus.dmem_wdata[15:0]}};
            end
            WIDTH_WORD: begin
                d_aligned_c = (bus.dmem_addr[1:0] == 2'b00);
                d_be_c      = 4'b1111;
            end
            default: ;
        endcase
        i_use_c = bus.imem_req & i_inrange_c;
        d_use_c = bus.dmem_req & d_inrange_c & d_aligned_c;
    end

    // Arbitration: dmem wins conflicts unless imem has lost STARVE_LIMIT in a row
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                conflict_c, imem_wins_c, i_ack_c, d_ack_c, i_go_c, d_go_c;

    always_comb begin
        conflict_c  = ~rst & i_use_c & d_use_c & (i_bank_c == d_bank_c);
        imem_wins_c = (starve_q == STARVE_W'(STARVE_LIMIT));
        i_ack_c     = ~rst & bus.imem_req & ~(conflict_c & ~imem_wins_c);
        d_ack_c     = ~rst & bus.dmem_req & ~(conflict_c & imem_wins_c);
        i_go_c      = i_ack_c & i_use_c;
        d_go_c      = d_ack_c & d_use_c;

        starve_d = starve_q;
        if (i_ack_c) begin
            starve_d = '0;
        end else if (conflict_c && !imem_wins_c) begin
            starve_d = starve_q + STARVE_W'(1);
        end

        cnt_d = cnt_q;
        if (conflict_c && cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
            cnt_q    <= '0;
        end else begin
            starve_q <= starve_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.imem_req_ack = i_ack_c;
    assign bus.dmem_req_ack = d_ack_c;
    assign conflict_cnt     = cnt_q;

    // Per-bank port steering; arbitration guarantees at most one port per bank
    logic [NUM_BANKS-1:0] bank_en_c, bank_we_c;
    logic [ROW_IW-1:0]    bank_row_c   [NUM_BANKS];
    logic [31:0]          bank_rdata_c [NUM_BANKS];

    always_comb begin
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            bank_en_c[b]  = 1'b0;
            bank_we_c[b]  = 1'b0;
            bank_row_c[b] = '0;
            if (i_go_c && i_bank_c == BANK_IW'(b)) begin
                bank_en_c[b]  = 1'b1;
                bank_row_c[b] = i_row_c;
            end
            if (d_go_c && d_bank_c == BANK_IW'(b)) begin
                bank_en_c[b]  = 1'b1;
                bank_we_c[b]  = d_wr_c;
                bank_row_c[b] = d_row_c;
            end
        end
    end

    for (genvar gb = 0; gb < NUM_BANKS; gb++) begin : g_bank
        logic [31:0] mem_q [ROWS];
        logic [31:0] rd_q;

        always_ff @(posedge clk) begin
            if (bank_en_c[gb]) begin
                if (bank_we_c[gb]) begin
                    for (int k = 0; k < 4; k++) begin
                        if (d_be_c[k]) begin
                            mem_q[bank_row_c[gb]][8*k +: 8] <= d_wdata_c[8*k +: 8];
                        end
                    end
                end else begin
                    rd_q <= mem_q[bank_row_c[gb]];
                end
            end
        end

        assign bank_rdata_c[gb] = rd_q;
    end

    // First response stage: request metadata captured at acceptance
    logic               i_v_q, i_err_q, d_v_q, d_err_q, d_wr_q;
    logic [BANK_IW-1:0] i_bank_q, d_bank_q;
    logic [1:0]         d_shift_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            i_v_q     <= 1'b0;
            i_err_q   <= 1'b0;
            i_bank_q  <= '0;
            d_v_q     <= 1'b0;
            d_err_q   <= 1'b0;
            d_wr_q    <= 1'b0;
            d_bank_q  <= '0;
            d_shift_q <= 2'b00;
        end else begin
            i_v_q     <= i_ack_c;
            i_err_q   <= ~i_use_c;
            i_bank_q  <= i_bank_c;
            d_v_q     <= d_ack_c;
            d_err_q   <= ~d_use_c;
            d_wr_q    <= d_wr_c;
            d_bank_q  <= d_bank_c;
            d_shift_q <= bus.dmem_addr[1:0];
        end
    end

    logic [1:0]  i_resp_c, d_resp_c;
    logic [31:0] i_rdata_c, d_rdata_c;

    always_comb begin
        i_resp_c  = RESP_NOTRDY;
        i_rdata_c = '0;
        d_resp_c  = RESP_NOTRDY;
        d_rdata_c = '0;
        if (i_v_q) begin
            i_resp_c  = i_err_q ? RESP_ER : RESP_OK;
            i_rdata_c = i_err_q ? 32'd0 : bank_rdata_c[i_bank_q];
        end
        if (d_v_q) begin
            d_resp_c = d_err_q ? RESP_ER : RESP_OK;
            if (!d_err_q && !d_wr_q) begin
                d_rdata_c = bank_rdata_c[d_bank_q] >> {d_shift_q, 3'b000};
            end
        end
    end

    // Optional extra output register stage
    if (RD_LATENCY >= 2) begin : g_lat2
        logic [1:0]  i_resp_q, d_resp_q;
        logic [31:0] i_rdata_q, d_rdata_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                i_resp_q  <= RESP_NOTRDY;
                i_rdata_q <= '0;
                d_resp_q  <= RESP_NOTRDY;
                d_rdata_q <= '0;
            end else begin
                i_resp_q  <= i_resp_c;
                i_rdata_q <= i_rdata_c;
                d_resp_q  <= d_resp_c;
                d_rdata_q <= d_rdata_c;
            end
        end

        assign bus.imem_resp  = i_resp_q;
        assign bus.imem_rdata = i_rdata_q;
        assign bus.dmem_resp  = d_resp_q;
        assign bus.dmem_rdata = d_rdata_q;
    end else begin : g_lat1
        assign bus.imem_resp  = i_resp_c;
        assign bus.imem_rdata = i_rdata_c;
        assign bus.dmem_resp  = d_resp_c;
        assign bus.dmem_rdata = d_rdata_c;
    end
endmodule

// File: tb/tb_scr1_tcm_banked.sv
// Bench for scr1_tcm_banked: latency-1 and latency-2 instances share one stimulus
// stream; a reference memory model feeds per-port expectation queues.
module tb_scr1_tcm_banked;
    localparam int unsigned SIZE = 32'h0001_0000;
    localparam logic [1:0] R_NO = 2'd0, R_OK = 2'd1, R_ER = 2'd2;
    localparam logic [1:0] W_B = 2'd0, W_H = 2'd1, W_W = 2'd2;
    localparam logic       C_RD = 1'b0, C_WR = 1'b1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [15:0] cc1, cc2;
    always #5 clk = ~clk;

    scr1_tcm_banked_if if1 ();
    scr1_tcm_banked_if if2 ();

    assign if2.imem_req   = if1.imem_req;
    assign if2.imem_addr  = if1.imem_addr;
    assign if2.dmem_req   = if1.dmem_req;
    assign if2.dmem_cmd   = if1.dmem_cmd;
    assign if2.dmem_width = if1.dmem_width;
    assign if2.dmem_addr  = if1.dmem_addr;
    assign if2.dmem_wdata = if1.dmem_wdata;

    scr1_tcm_banked #(.SCR1_TCM_SIZE(SIZE), .NUM_BANKS(2), .RD_LATENCY(1), .STARVE_LIMIT(4))
        u_dut1 (.clk(clk), .rst(rst), .bus(if1), .conflict_cnt(cc1));
    scr1_tcm_banked #(.SCR1_TCM_SIZE(SIZE), .NUM_BANKS(2), .RD_LATENCY(2), .STARVE_LIMIT(4))
        u_dut2 (.clk(clk), .rst(rst), .bus(if2), .conflict_cnt(cc2));

    typedef struct {
        int          due;
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_t;

    // 0: lat1 imem, 1: lat1 dmem, 2: lat2 imem, 3: lat2 dmem
    exp_t        sbq [4][$];
    logic [31:0] mdl [int];
    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic mon(input int idx, input logic [1:0] resp, input logic [31:0] data);
        exp_t e;
        if (resp !== R_NO) begin
            if (sbq[idx].size() == 0) begin
                chk($sformatf("unexpected_resp_q%0d", idx), 32'(resp), 32'(R_NO));
            end else begin
                e = sbq[idx].pop_front();
                chk($sformatf("resp_q%0d", idx), 32'(resp), 32'(e.resp));
                chk($sformatf("rdata_q%0d", idx), data, e.data);
                chk($sformatf("resp_cycle_q%0d", idx), 32'(cyc), 32'(e.due));
            end
        end else if (sbq[idx].size() != 0 && sbq[idx][0].due <= cyc) begin
            e = sbq[idx].pop_front();
            chk($sformatf("missing_resp_q%0d", idx), 32'(resp), 32'(e.resp));
        end
    endtask

    always @(negedge clk) begin
        mon(0, if1.imem_resp, if1.imem_rdata);
        mon(1, if1.dmem_resp, if1.dmem_rdata);
        mon(2, if2.imem_resp, if2.imem_rdata);
        mon(3, if2.dmem_resp, if2.dmem_rdata);
    end

    // Reset drops every in-flight response
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) sbq[i].delete();
        end
        cyc = cyc + 1;
    end

    function automatic logic [31:0] word_at(input logic [31:0] a);
        int key;
        key = int'(a >> 2);
        return mdl.exists(key) ? mdl[key] : 32'd0;
    endfunction

    task automatic push2(input int base, input logic [1:0] resp, input logic [31:0] data);
        exp_t e;
        e.resp = resp;
        e.data = data;
        e.due  = cyc + 1;
        sbq[base].push_back(e);
        e.due  = cyc + 2;
        sbq[base + 2].push_back(e);
    endtask

    // One clock of stimulus; starts and ends just after a falling edge
    task automatic step(input logic ireq, input logic [31:0] iaddr,
                        input logic dreq, input logic dcmd, input logic [1:0] dw,
                        input logic [31:0] daddr, input logic [31:0] dwd,
                        input logic exp_iack, input logic exp_dack);
        logic        ok;
        logic [31:0] w;
        if1.imem_req   = ireq;
        if1.imem_addr  = iaddr;
        if1.dmem_req   = dreq;
        if1.dmem_cmd   = dcmd;
        if1.dmem_width = dw;
        if1.dmem_addr  = daddr;
        if1.dmem_wdata = dwd;
        #1;
        chk("imem_req_ack_lat1", 32'(if1.imem_req_ack), 32'(exp_iack));
        chk("dmem_req_ack_lat1", 32'(if1.dmem_req_ack), 32'(exp_dack));
        chk("imem_req_ack_lat2", 32'(if2.imem_req_ack), 32'(exp_iack));
        chk("dmem_req_ack_lat2", 32'(if2.dmem_req_ack), 32'(exp_dack));
        if (exp_iack) begin
            if (iaddr < SIZE) push2(0, R_OK, word_at(iaddr));
            else              push2(0, R_ER, 32'd0);
        end
        if (exp_dack) begin
            case (dw)
                W_B:     ok = 1'b1;
                W_H:     ok = ~daddr[0];
                W_W:     ok = (daddr[1:0] == 2'b00);
                default: ok = 1'b0;
            endcase
            ok = ok && (daddr < SIZE);
            if (!ok) begin
                push2(1, R_ER, 32'd0);
            end else if (dcmd == C_WR) begin
                w = word_at(daddr);
                case (dw)
                    W_B:     w[8*daddr[1:0] +: 8] = dwd[7:0];
                    W_H:     w[16*daddr[1] +: 16] = dwd[15:0];
                    default: w = dwd;
                endcase
                mdl[int'(daddr >> 2)] = w;
                push2(1, R_OK, 32'd0);
            end else begin
                push2(1, R_OK, word_at(daddr) >> (8 * daddr[1:0]));
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 32'd0, 1'b0, C_RD, W_W, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    initial begin
        if1.imem_req   = 1'b0;
        if1.imem_addr  = '0;
        if1.dmem_req   = 1'b0;
        if1.dmem_cmd   = C_RD;
        if1.dmem_width = W_W;
        if1.dmem_addr  = '0;
        if1.dmem_wdata = '0;
        repeat (3) @(negedge clk);

        // Requests held during reset are never acknowledged
        step(1'b1, 32'h0, 1'b1, C_RD, W_W, 32'h4, 32'd0, 1'b0, 1'b0);
        chk("rst_imem_resp_lat1", 32'(if1.imem_resp), 32'(R_NO));
        chk("rst_dmem_resp_lat2", 32'(if2.dmem_resp), 32'(R_NO));
        chk("rst_dmem_rdata_lat1", if1.dmem_rdata, 32'd0);
        chk("rst_imem_rdata_lat2", if2.imem_rdata, 32'd0);
        chk("rst_conflict_cnt", 32'(cc1), 32'd0);
        rst = 1'b0;

        // Word write, then word / byte / halfword reads
        step(1'b0, 32'h0, 1'b1, C_WR, W_W, 32'h10, 32'h1122_3344, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, C_RD, W_W, 32'h10, 32'd0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, C_RD, W_B, 32'h12, 32'd0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, C_RD, W_H, 32'h12, 32'd0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, C_WR, W_B, 32'h11, 32'h0000_00AB, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, C_WR, W_H, 32'h16, 32'h0000_BEEF, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, C_RD, W_B, 32'h11, 32'd0, 1'b0, 1'b1);
        step(1'b1, 32'h10, 1'b1, C_RD, W_W, 32'h14, 32'd0, 1'b1, 1'b1);

        // Preload words in both banks
        step(1'b0, 32'h0, 1'b1, C_WR, W_W, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, C_WR, W_W, 32'h4, 32'h0123_4567, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, C_WR, W_W, 32'h8, 32'h89AB_CDEF, 1'b0, 1'b1);

        // Different banks proceed in parallel
        step(1'b1, 32'h0, 1'b1, C_RD, W_W, 32'h4, 32'd0, 1'b1, 1'b1);
        chk("no_conflict_cnt", 32'(cc1), 32'd0);

        // Sustained conflict: dmem wins four, imem wins the fifth
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 32'h0, 1'b1, C_RD, W_W, 32'h8, 32'd0, (k % 5) == 4, (k % 5) != 4);
        end
        chk("conflict_cnt_10_lat1", 32'(cc1), 32'd10);
        chk("conflict_cnt_10_lat2", 32'(cc2), 32'd10);
        step(1'b1, 32'h0, 1'b1, C_RD, W_W, 32'h8, 32'd0, 1'b0, 1'b1);
        chk("conflict_cnt_11", 32'(cc1), 32'd11);

        // Misaligned request occupies no bank, so no conflict
        step(1'b1, 32'h0, 1'b1, C_RD, W_W, 32'h2, 32'd0, 1'b1, 1'b1);
        chk("misaligned_no_conflict", 32'(cc1), 32'd11);
        step(1'b0, 32'h0, 1'b1, C_WR, W_H, 32'h1, 32'h0000_FFFF, 1'b0, 1'b1);
        step(1'b1, SIZE, 1'b1, C_RD, W_W, SIZE, 32'd0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, C_WR, W_W, SIZE + 32'h4, 32'hFFFF_FFFF, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, C_RD, W_W, 32'h0, 32'd0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, C_RD, W_W, 32'h4, 32'd0, 1'b0, 1'b1);

        // Back-to-back reads on consecutive cycles
        step(1'b0, 32'h0, 1'b1, C_RD, W_W, 32'h0, 32'd0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, C_RD, W_W, 32'h4, 32'd0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, C_RD, W_W, 32'h8, 32'd0, 1'b0, 1'b1);

        // Read the cycle after a write sees the new data
        step(1'b0, 32'h0, 1'b1, C_WR, W_W, 32'h20, 32'hDEAD_BEEF, 1'b0, 1'b1);
        step(1'b1, 32'h20, 1'b1, C_RD, W_H, 32'h22, 32'd0, 1'b0, 1'b1);
        step(1'b1, 32'h20, 1'b0, C_RD, W_W, 32'h0, 32'd0, 1'b1, 1'b0);
        idle();
        idle();

        // Reset right after an accept drops the pending response
        step(1'b0, 32'h0, 1'b1, C_RD, W_W, 32'h4, 32'd0, 1'b0, 1'b1);
        rst = 1'b1;
        idle();
        chk("post_rst_imem_resp_lat2", 32'(if2.imem_resp), 32'(R_NO));
        chk("post_rst_dmem_resp_lat2", 32'(if2.dmem_resp), 32'(R_NO));
        chk("post_rst_dmem_resp_lat1", 32'(if1.dmem_resp), 32'(R_NO));
        chk("post_rst_conflict_cnt_lat1", 32'(cc1), 32'd0);
        chk("post_rst_conflict_cnt_lat2", 32'(cc2), 32'd0);
        rst = 1'b0;
        idle();
        idle();
        idle();
        chk("scoreboard_drained",
            32'(sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
